// File: rtl/cmsdk_mcu_mtx_dec_param.sv
// cmsdk_mcu_mtx_dec_param: parametrised matrix input decoder with boot-remap alias,
// integrated two-cycle ERROR default slave and saturating unmapped-access counter.
module cmsdk_mcu_mtx_dec_param #(
    parameter int NUM_PORTS = 2,
    parameter int RUSER_W = 3,
    parameter logic [22*NUM_PORTS-1:0] REGION_BASE = '0,
    parameter logic [22*NUM_PORTS-1:0] REGION_MASK = '0,
    parameter int REMAP_PORT = 1
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic                         HREADYS,
    input  logic                         sel_dec,
    input  logic [21:0]                  decode_addr_dec,
    input  logic [1:0]                   trans_dec,
    input  logic                         remap,
    input  logic [NUM_PORTS-1:0]         active_dec_i,
    input  logic [NUM_PORTS-1:0]         readyout_dec_i,
    input  logic [2*NUM_PORTS-1:0]       resp_dec_i,
    input  logic [32*NUM_PORTS-1:0]      rdata_dec_i,
    input  logic [RUSER_W*NUM_PORTS-1:0] ruser_dec_i,
    input  logic                         err_clr,
    output logic [NUM_PORTS-1:0]         sel_dec_o,
    output logic                         active_dec,
    output logic                         HREADYOUTS,
    output logic [1:0]                   HRESPS,
    output logic [31:0]                  HRDATAS,
    output logic [RUSER_W-1:0]           HRUSERS,
    output logic [7:0]                   err_cnt
);
    localparam int PW = $clog2(NUM_PORTS + 1);
    localparam logic [PW-1:0] DFT = PW'(NUM_PORTS);

    typedef enum logic [1:0] {OK, ERR1, ERR2} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   data_port_q, data_port_d, addr_port, match_port;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic            match0, sel_dft, err_start, dft_ready;
    logic [1:0]      dft_resp;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        match_port = DFT;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (((decode_addr_dec ^ REGION_BASE[22*i +: 22]) & REGION_MASK[22*i +: 22]) == '0)
                match_port = PW'(i);
        end
        match0 = ((decode_addr_dec ^ REGION_BASE[21:0]) & REGION_MASK[21:0]) == '0;
        addr_port = (trans_dec == 2'b00) ? data_port_q :
                    (remap && match0) ? PW'(REMAP_PORT) : match_port;
    end

    always_comb begin
        sel_dec_o = '0;
        active_dec = 1'b1;
        for (int i = 0; i < NUM_PORTS; i++) begin
            sel_dec_o[i] = sel_dec && (addr_port == PW'(i));
            if (addr_port == PW'(i))
                active_dec = active_dec_i[i];
        end
        sel_dft = sel_dec && (addr_port == DFT);
        err_start = sel_dft && HREADYS && trans_dec[1];
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= OK;
            data_port_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            data_port_q <= data_port_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        state_d = (state_q == ERR1) ? ERR2 : err_start ? ERR1 : OK;
        data_port_d = HREADYS ? addr_port : data_port_q;
        err_cnt_d = err_clr ? 8'd0 :
                    (err_start && state_q != ERR1 && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_comb begin
        dft_ready = state_q != ERR1;
        dft_resp = (state_q == OK) ? 2'b00 : 2'b01;
    end

    always_comb begin
        HREADYOUTS = dft_ready;
        HRESPS = dft_resp;
        HRDATAS = '0;
        HRUSERS = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (data_port_q == PW'(i)) begin
                HREADYOUTS = readyout_dec_i[i];
                HRESPS = resp_dec_i[2*i +: 2];
                HRDATAS = rdata_dec_i[32*i +: 32];
                HRUSERS = ruser_dec_i[RUSER_W*i +: RUSER_W];
            end
        end
    end

    assign err_cnt = err_cnt_q;
endmodule

// File: tb/tb_cmsdk_mcu_mtx_dec_param.sv
// tb_cmsdk_mcu_mtx_dec_param: directed bench for the matrix input decoder,
// two ports with a narrowed port-1 region leaving 0xC000_0000 unmapped.
module tb_cmsdk_mcu_mtx_dec_param;
    localparam logic [43:0] BASE = {22'h080000, 22'h000000};
    localparam logic [43:0] MASK = {22'h380000, 22'h380000};
    localparam logic [31:0] RD0 = 32'hAAAA_0000;
    localparam logic [31:0] RD1 = 32'h5555_1111;

    logic        HCLK = 1'b0;
    logic        HRESETn, HREADYS, sel_dec, remap, err_clr;
    logic [31:0] haddr;
    logic [1:0]  trans_dec;
    logic [1:0]  active_dec_i, readyout_dec_i;
    logic [3:0]  resp_dec_i;
    logic [63:0] rdata_dec_i;
    logic [5:0]  ruser_dec_i;
    logic [1:0]  sel_dec_o;
    logic        active_dec, HREADYOUTS;
    logic [1:0]  HRESPS;
    logic [31:0] HRDATAS;
    logic [2:0]  HRUSERS;
    logic [7:0]  err_cnt;
    int total = 0;
    int bad = 0;

    cmsdk_mcu_mtx_dec_param #(
        .NUM_PORTS(2), .RUSER_W(3), .REGION_BASE(BASE), .REGION_MASK(MASK), .REMAP_PORT(1)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HREADYS(HREADYS), .sel_dec(sel_dec),
        .decode_addr_dec(haddr[31:10]), .trans_dec(trans_dec), .remap(remap),
        .active_dec_i(active_dec_i), .readyout_dec_i(readyout_dec_i), .resp_dec_i(resp_dec_i),
        .rdata_dec_i(rdata_dec_i), .ruser_dec_i(ruser_dec_i), .err_clr(err_clr),
        .sel_dec_o(sel_dec_o), .active_dec(active_dec), .HREADYOUTS(HREADYOUTS),
        .HRESPS(HRESPS), .HRDATAS(HRDATAS), .HRUSERS(HRUSERS), .err_cnt(err_cnt)
    );

    always #5 HCLK = ~HCLK;

    task tick;
        @(posedge HCLK);
        #1;
    endtask

    task test_reset;
        HRESETn = 1'b0; HREADYS = 1'b1; sel_dec = 1'b0; remap = 1'b0; err_clr = 1'b0;
        haddr = '0; trans_dec = 2'b00; active_dec_i = 2'b10; readyout_dec_i = 2'b01;
        resp_dec_i = 4'b0100; rdata_dec_i = {RD1, RD0}; ruser_dec_i = {3'b010, 3'b101};
        #12;
        total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", err_cnt); end
        total++; if (HREADYOUTS !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", HREADYOUTS); end
        total++; if (HRDATAS !== RD0) begin bad++; $display("FAIL reset_rdata got=%h want=%h", HRDATAS, RD0); end
        readyout_dec_i = 2'b10; #1;
        total++; if (HREADYOUTS !== 1'b0) begin bad++; $display("FAIL reset_ready0 got=%b want=0", HREADYOUTS); end
        readyout_dec_i = 2'b11;
        tick;
        HRESETn = 1'b1;
    endtask

    task test_decode;
        sel_dec = 1'b1; trans_dec = 2'b10; haddr = 32'h2000_0000; #1;
        total++; if (sel_dec_o !== 2'b10) begin bad++; $display("FAIL decode_sel got=%b want=10", sel_dec_o); end
        total++; if (active_dec !== 1'b1) begin bad++; $display("FAIL decode_active got=%b want=1", active_dec); end
        total++; if (HRDATAS !== RD0) begin bad++; $display("FAIL decode_addr_phase_rdata got=%h want=%h", HRDATAS, RD0); end
        tick;
        trans_dec = 2'b00; haddr = 32'h0; #1;
        total++; if (HRDATAS !== RD1) begin bad++; $display("FAIL decode_rdata got=%h want=%h", HRDATAS, RD1); end
        total++; if (HRUSERS !== 3'b010) begin bad++; $display("FAIL decode_ruser got=%b want=010", HRUSERS); end
        total++; if (HRESPS !== 2'b01) begin bad++; $display("FAIL decode_resp got=%b want=01", HRESPS); end
    endtask

    task test_idle_hold;
        total++; if (sel_dec_o !== 2'b10) begin bad++; $display("FAIL idle_sel got=%b want=10", sel_dec_o); end
        tick;
        total++; if (HRDATAS !== RD1) begin bad++; $display("FAIL idle_rdata got=%h want=%h", HRDATAS, RD1); end
    endtask

    task test_remap;
        trans_dec = 2'b10; haddr = 32'h0000_0100; remap = 1'b1; #1;
        total++; if (sel_dec_o !== 2'b10) begin bad++; $display("FAIL remap_on_sel got=%b want=10", sel_dec_o); end
        remap = 1'b0; #1;
        total++; if (sel_dec_o !== 2'b01) begin bad++; $display("FAIL remap_off_sel got=%b want=01", sel_dec_o); end
        total++; if (active_dec !== 1'b0) begin bad++; $display("FAIL remap_off_active got=%b want=0", active_dec); end
        sel_dec = 1'b0; #1;
        total++; if (sel_dec_o !== 2'b00) begin bad++; $display("FAIL nosel got=%b want=00", sel_dec_o); end
        sel_dec = 1'b1; HREADYS = 1'b0;
        tick;
        total++; if (HRDATAS !== RD1) begin bad++; $display("FAIL wait_hold_rdata got=%h want=%h", HRDATAS, RD1); end
        HREADYS = 1'b1;
        tick;
        total++; if (HRDATAS !== RD0) begin bad++; $display("FAIL remap_data_rdata got=%h want=%h", HRDATAS, RD0); end
    endtask

    task test_default_slave;
        active_dec_i = 2'b00; haddr = 32'hC000_0000; trans_dec = 2'b10; #1;
        total++; if (sel_dec_o !== 2'b00) begin bad++; $display("FAIL dft_sel got=%b want=00", sel_dec_o); end
        total++; if (active_dec !== 1'b1) begin bad++; $display("FAIL dft_active got=%b want=1", active_dec); end
        tick;
        HREADYS = 1'b0; trans_dec = 2'b00; #1;
        total++; if ({HREADYOUTS, HRESPS} !== 3'b001) begin bad++; $display("FAIL dft_err1 got=%b want=001", {HREADYOUTS, HRESPS}); end
        total++; if ({HRDATAS, HRUSERS} !== 35'd0) begin bad++; $display("FAIL dft_data got=%h want=0", {HRDATAS, HRUSERS}); end
        tick;
        HREADYS = 1'b1; #1;
        total++; if ({HREADYOUTS, HRESPS} !== 3'b101) begin bad++; $display("FAIL dft_err2 got=%b want=101", {HREADYOUTS, HRESPS}); end
        tick;
        total++; if ({HREADYOUTS, HRESPS} !== 3'b100) begin bad++; $display("FAIL dft_ok got=%b want=100", {HREADYOUTS, HRESPS}); end
        total++; if (err_cnt !== 8'd1) begin bad++; $display("FAIL dft_cnt got=%0d want=1", err_cnt); end
    endtask

    task test_back_to_back;
        trans_dec = 2'b10; HREADYS = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick;
            HREADYS = 1'b0; #1;
            total++; if ({HREADYOUTS, HRESPS} !== 3'b001) begin bad++; $display("FAIL b2b_err1_%0d got=%b want=001", k, {HREADYOUTS, HRESPS}); end
            tick;
            HREADYS = 1'b1; #1;
            total++; if ({HREADYOUTS, HRESPS} !== 3'b101) begin bad++; $display("FAIL b2b_err2_%0d got=%b want=101", k, {HREADYOUTS, HRESPS}); end
        end
        trans_dec = 2'b00;
        tick;
        total++; if ({HREADYOUTS, HRESPS} !== 3'b100) begin bad++; $display("FAIL b2b_ok got=%b want=100", {HREADYOUTS, HRESPS}); end
        total++; if (err_cnt !== 8'd3) begin bad++; $display("FAIL b2b_cnt got=%0d want=3", err_cnt); end
    endtask

    task test_saturate;
        for (int k = 0; k < 260; k++) begin
            trans_dec = 2'b10; HREADYS = 1'b1;
            tick;
            HREADYS = 1'b0;
            tick;
        end
        trans_dec = 2'b00; HREADYS = 1'b1;
        tick;
        total++; if (err_cnt !== 8'd255) begin bad++; $display("FAIL sat_cnt got=%0d want=255", err_cnt); end
        trans_dec = 2'b10; err_clr = 1'b1;
        tick;
        err_clr = 1'b0; #1;
        total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL clr_cnt got=%0d want=0", err_cnt); end
        HREADYS = 1'b0;
        tick;
        HREADYS = 1'b1;
        tick;
        total++; if (err_cnt !== 8'd1) begin bad++; $display("FAIL clr_recount got=%0d want=1", err_cnt); end
    endtask

    task test_reset_mid;
        HREADYS = 1'b0; readyout_dec_i = 2'b01; #1;
        total++; if (HREADYOUTS !== 1'b0) begin bad++; $display("FAIL mid_pre_ready got=%b want=0", HREADYOUTS); end
        HRESETn = 1'b0; #1;
        total++; if ({HREADYOUTS, HRESPS} !== 3'b100) begin bad++; $display("FAIL mid_rst_resp got=%b want=100", {HREADYOUTS, HRESPS}); end
        total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL mid_rst_cnt got=%0d want=0", err_cnt); end
        tick;
        HRESETn = 1'b1; trans_dec = 2'b00; sel_dec = 1'b0; HREADYS = 1'b1;
        tick;
        total++; if ({HREADYOUTS, HRESPS} !== 3'b100) begin bad++; $display("FAIL mid_after got=%b want=100", {HREADYOUTS, HRESPS}); end
        total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL mid_after_cnt got=%0d want=0", err_cnt); end
    endtask

    initial begin
        test_reset;
        test_decode;
        test_idle_hold;
        test_remap;
        test_default_slave;
        test_back_to_back;
        test_saturate;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
